// File: rtl/gol_vga_renderer.sv
// 640x480@60 VGA raster for a 16x16 Game of Life board with an editing-cursor outline.
// The board is snapshotted on the last pixel of each frame so a generation update never tears the image.
module gol_vga_renderer #(
   parameter int          CLK_DIV    = 4,
   parameter int          CELL_SHIFT = 4,
   parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
   parameter logic [11:0] DEAD_RGB   = 12'h000,
   parameter logic [11:0] BG_RGB     = 12'h222,
   parameter logic [11:0] CURSOR_RGB = 12'hF00
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] board_i,
   input  logic [3:0]   cursor_row,
   input  logic [3:0]   cursor_col,
   input  logic         cursor_en,
   output logic         hsync,
   output logic         vsync,
   output logic [11:0]  rgb,
   output logic         frame_start
);

   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_LAST = 10'd799;
   localparam logic [9:0] V_LAST = 10'd524;
   localparam logic [9:0] H_VIS  = 10'd640;
   localparam logic [9:0] V_VIS  = 10'd480;
   localparam logic [9:0] HS_BEG = 10'd656;
   localparam logic [9:0] HS_END = 10'd752;
   localparam logic [9:0] VS_BEG = 10'd490;
   localparam logic [9:0] VS_END = 10'd492;

   localparam int         SIDE = 16 << CELL_SHIFT;
   localparam int         LW   = CELL_SHIFT + 4;
   localparam logic [9:0] X0   = 10'(320 - SIDE / 2);
   localparam logic [9:0] X1   = 10'(320 + SIDE / 2);
   localparam logic [9:0] Y0   = 10'(240 - SIDE / 2);
   localparam logic [9:0] Y1   = 10'(240 + SIDE / 2);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic [255:0]     snap_q, snap_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [11:0]      rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;

   logic                  tick;
   logic                  visible;
   logic                  in_board;
   logic [LW-1:0]         dx, dy;
   logic [3:0]            col, row;
   logic [CELL_SHIFT-1:0] off_x, off_y;
   logic                  on_ring;
   logic                  cursor_hit;
   logic [11:0]           pix_rgb;

   assign tick = (div_q == DIV_LAST);

   // Cell coordinates only matter inside the board, so the offset is kept just wide enough for 16 cells.
   assign dx         = LW'(h_q - X0);
   assign dy         = LW'(v_q - Y0);
   assign col        = dx[LW-1:CELL_SHIFT];
   assign row        = dy[LW-1:CELL_SHIFT];
   assign off_x      = dx[CELL_SHIFT-1:0];
   assign off_y      = dy[CELL_SHIFT-1:0];
   assign visible    = (h_q < H_VIS) && (v_q < V_VIS);
   assign in_board   = (h_q >= X0) && (h_q < X1) && (v_q >= Y0) && (v_q < Y1);
   assign on_ring    = (off_x == '0) || (off_x == '1) || (off_y == '0) || (off_y == '1);
   assign cursor_hit = cursor_en && (row == cursor_row) && (col == cursor_col) && on_ring;

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      h_d    = h_q;
      v_d    = v_q;
      snap_d = snap_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            if (v_q == V_LAST) begin
               snap_d = board_i;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_comb begin
      pix_rgb = 12'h000;
      if (visible) begin
         if (!in_board) begin
            pix_rgb = BG_RGB;
         end else if (cursor_hit) begin
            pix_rgb = CURSOR_RGB;
         end else if (snap_q[{row, col}]) begin
            pix_rgb = ALIVE_RGB;
         end else begin
            pix_rgb = DEAD_RGB;
         end
      end
   end

   // Outputs describe the pixel at the pre-increment counters and hold between ticks.
   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      if (tick) begin
         hsync_d       = !((h_q >= HS_BEG) && (h_q < HS_END));
         vsync_d       = !((v_q >= VS_BEG) && (v_q < VS_END));
         rgb_d         = pix_rgb;
         frame_start_d = (h_q == '0) && (v_q == '0);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         // NOTE: the snapshot is a plain register that must read all-dead after reset, so it is reset like any other flop.
         snap_q        <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         snap_q        <= snap_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_gol_vga_renderer.sv
// Randomized bench for gol_vga_renderer: a CLK_DIV=1 instance checked pixel-by-pixel against a
// geometric reference model, plus a CLK_DIV=4 instance checked for tick latency and line timing.
module tb_gol_vga_renderer;

   localparam int FRAME_PIX = 800 * 525;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] board;
   logic [3:0]   crow, ccol;
   logic         cen;

   logic         hsync, vsync, frame_start;
   logic [11:0]  rgb;
   logic         hsync4, vsync4, frame_start4;
   logic [11:0]  rgb4;

   int n_checks = 0;
   int n_errors = 0;
   bit released = 1'b0;

   // Reference-model state
   int           p;
   int           frame;
   logic [255:0] m_snap;
   int           line_err;
   int           bad_x;
   logic [14:0]  bad_got, bad_exp;

   logic [11:0] spot_rgb  [int];
   logic [1:0]  spot_sync [int];

   always #5 clk = ~clk;

   gol_vga_renderer #(.CLK_DIV(1)) u_dut (
      .clk(clk), .reset(reset), .board_i(board),
      .cursor_row(crow), .cursor_col(ccol), .cursor_en(cen),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
   );

   gol_vga_renderer u_dut4 (
      .clk(clk), .reset(reset), .board_i(board),
      .cursor_row(crow), .cursor_col(ccol), .cursor_en(cen),
      .hsync(hsync4), .vsync(vsync4), .rgb(rgb4), .frame_start(frame_start4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {frame_start, hsync, vsync, rgb} for frame pixel p, straight from the raster geometry.
   function automatic logic [14:0] ref_out(input int pix, input logic [255:0] snap,
                                           input int cr, input int cc, input bit ce);
      int x, y, col, row, ox, oy;
      logic [11:0] c;
      x = pix % 800;
      y = pix / 800;
      c = 12'h000;
      if (x < 640 && y < 480) begin
         if (x < 192 || x >= 448 || y < 112 || y >= 368) begin
            c = 12'h222;
         end else begin
            col = (x - 192) / 16;
            row = (y - 112) / 16;
            ox  = (x - 192) % 16;
            oy  = (y - 112) % 16;
            if (ce && row == cr && col == cc && (ox == 0 || ox == 15 || oy == 0 || oy == 15))
               c = 12'hF00;
            else
               c = snap[row * 16 + col] ? 12'hFFF : 12'h000;
         end
      end
      return {(pix == 0), !(x >= 656 && x < 752), !(y >= 490 && y < 492), c};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic rand_cursor();
      crow = 4'($urandom_range(15));
      ccol = 4'($urandom_range(15));
      cen  = 1'($urandom_range(1));
   endtask

   task automatic add_rgb(input int f, input int x, input int y, input logic [11:0] c);
      spot_rgb[f * FRAME_PIX + y * 800 + x] = c;
   endtask

   task automatic add_sync(input int f, input int x, input int y, input logic [1:0] hv);
      spot_sync[f * FRAME_PIX + y * 800 + x] = hv;
   endtask

   // Input pattern for the pixel about to be loaded.
   task automatic drive(input int x, input int y);
      logic [255:0] keep;
      keep = '0;
      keep[255] = 1'b1;
      keep[53]  = 1'b1;
      case (frame)
         0: begin
            if (y == 524 && x == 0) board = 256'h1;
            else if (y < 524 && $urandom_range(511) == 0) board = rand256();
            if ($urandom_range(31) == 0) rand_cursor();
         end
         1: begin
            if (y < 200) begin
               crow = 4'd3; ccol = 4'd5; cen = 1'b1;
            end else begin
               if (y == 200 && x == 0) board = rand256() | keep;
               else if ($urandom_range(511) == 0) board = rand256() | keep;
               if ($urandom_range(31) == 0) rand_cursor();
            end
         end
         2: begin
            if (y < 200) begin
               crow = 4'd3; ccol = 4'd5; cen = 1'b0;
            end else if ($urandom_range(31) == 0) begin
               rand_cursor();
            end
            if ($urandom_range(511) == 0) board = rand256();
         end
         default: begin
            cen = 1'b0;
            if ($urandom_range(511) == 0) board = rand256();
         end
      endcase
   endtask

   task automatic flush_line(input int y);
      check($sformatf("f%0d_line%0d_bad_pixels(first_x=%0d got=%h exp=%h)",
                      frame, y, bad_x, bad_got, bad_exp), line_err, 0);
      line_err = 0;
   endtask

   // One pixel: drive, predict, clock, compare.
   task automatic step();
      int x, y, key;
      logic [14:0] exp, got;
      x = p % 800;
      y = p / 800;
      drive(x, y);
      exp = ref_out(p, m_snap, int'(crow), int'(ccol), cen);
      @(posedge clk);
      if (p == FRAME_PIX - 1) m_snap = board;
      @(negedge clk);
      got = {frame_start, hsync, vsync, rgb};
      if (got !== exp) begin
         if (line_err == 0) begin
            bad_x = x; bad_got = got; bad_exp = exp;
         end
         line_err++;
      end
      key = frame * FRAME_PIX + p;
      if (spot_rgb.exists(key))
         check($sformatf("f%0d_rgb_%0d_%0d", frame, x, y), rgb, spot_rgb[key]);
      if (spot_sync.exists(key))
         check($sformatf("f%0d_hv_%0d_%0d", frame, x, y), {hsync, vsync}, spot_sync[key]);
      if (x == 799) flush_line(y);
      p++;
      if (p == FRAME_PIX) begin
         p = 0;
         frame++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hsync"}, hsync, 1'b1);
      check({tag, "_vsync"}, vsync, 1'b1);
      check({tag, "_rgb"}, rgb, 12'h000);
      check({tag, "_frame_start"}, frame_start, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      board = '0;
      crow  = '0;
      ccol  = '0;
      cen   = 1'b0;
      line_err = 0;
      bad_x = 0; bad_got = '0; bad_exp = '0;

      // Frame 1 shows bit 0 only, cursor (3,5) enabled for the top rows.
      add_rgb(1, 192, 112, 12'hFFF);
      add_rgb(1, 207, 127, 12'hFFF);
      add_rgb(1, 200, 120, 12'hFFF);
      add_rgb(1, 208, 112, 12'h000);
      add_rgb(1, 191, 112, 12'h222);
      add_rgb(1, 650, 10,  12'h000);
      add_rgb(1, 272, 160, 12'hF00);
      add_rgb(1, 287, 175, 12'hF00);
      add_rgb(1, 272, 170, 12'hF00);
      add_rgb(1, 280, 160, 12'hF00);
      add_rgb(1, 280, 168, 12'h000);
      add_rgb(1, 440, 360, 12'h000);
      add_sync(1, 655, 0, 2'b11);
      add_sync(1, 656, 0, 2'b01);
      add_sync(1, 751, 0, 2'b01);
      add_sync(1, 752, 0, 2'b11);
      add_sync(1, 0, 489, 2'b11);
      add_sync(1, 0, 490, 2'b10);
      add_sync(1, 0, 491, 2'b10);
      add_sync(1, 0, 492, 2'b11);
      add_sync(1, 700, 490, 2'b00);
      // Frame 2: bit 255 toggled mid-frame 1 now visible; cell (3,5) alive with cursor disabled.
      add_rgb(2, 440, 360, 12'hFFF);
      add_rgb(2, 272, 160, 12'hFFF);
      add_rgb(2, 280, 168, 12'hFFF);
      // First frame after a mid-frame reset: snapshot is dead again.
      add_rgb(3, 200, 120, 12'h000);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      reset    = 1'b0;
      released = 1'b1;
      p        = 0;
      frame    = 0;
      m_snap   = '0;

      while (!(frame == 2 && p == 300 * 800 + 400)) step();
      flush_line(300);

      reset = 1'b1;
      #1;
      check_reset_outputs("midframe_reset");
      repeat (2) @(negedge clk);
      check_reset_outputs("midframe_reset_held");

      reset  = 1'b0;
      p      = 0;
      frame  = 3;
      m_snap = '0;
      while (!(frame == 3 && p == 131 * 800)) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Default-divider instance: first tick latency, frame_start width, hsync placement and line period.
   initial begin
      int fs_first, fs_count, hs_fall1, hs_fall2, hs_rise1;
      logic hs_prev;
      fs_first = -1; fs_count = 0; hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
      wait (released);
      hs_prev = hsync4;
      for (int k = 1; k <= 6000; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) check("div4_idle_before_first_tick", {hsync4, vsync4, frame_start4, rgb4}, {3'b110, 12'h000});
         if (k == 4) check("div4_first_pixel_rgb", rgb4, 12'h222);
         if (frame_start4) begin
            fs_count++;
            if (fs_first < 0) fs_first = k;
         end
         if (hs_prev && !hsync4) begin
            if (hs_fall1 < 0) hs_fall1 = k;
            else if (hs_fall2 < 0) hs_fall2 = k;
         end
         if (!hs_prev && hsync4 && hs_rise1 < 0) hs_rise1 = k;
         hs_prev = hsync4;
      end
      check("div4_first_frame_start_clk", fs_first, 4);
      check("div4_frame_start_clks", fs_count, 1);
      check("div4_hsync_fall_clk", hs_fall1, 2628);
      check("div4_hsync_rise_clk", hs_rise1, 3012);
      check("div4_line_period_clk", hs_fall2 - hs_fall1, 3200);
   end

endmodule
